// File: rtl/dvp_tx.sv
// DVP (OV5640-style) sensor-side transmitter: RGB565 pixels in, high/low byte pairs out with PCLK/HREF/VSYNC.
// Define DVP_TX_TESTPAT_EN to add the test_mode input and the internal 8-colour bar generator.
module dvp_tx #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_BLANK   = 64,
  parameter int V_ACTIVE  = 768,
  parameter int VSYNC_LEN = 4,
  parameter int V_BACK    = 16,
  parameter int V_FRONT   = 4,
  parameter int CW        = 12
) (
  input  logic        CLOCK,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
`ifdef DVP_TX_TESTPAT_EN
  input  logic        test_mode,
`endif
  output logic        pix_ready,
  output logic        DVP_PCLK,
  output logic        DVP_HREF,
  output logic        DVP_VSYNC,
  output logic [7:0]  DVP_DATA,
  output logic        frame_done,
  output logic        underflow
);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  localparam logic [CW-1:0] TICK_LAST = CW'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [CW-1:0] HREF_END  = CW'(2 * H_ACTIVE);
  localparam logic [CW-1:0] VS_LAST   = CW'(VSYNC_LEN - 1);
  localparam logic [CW-1:0] VB_LAST   = CW'((V_BACK > 0) ? V_BACK - 1 : 0);
  localparam logic [CW-1:0] VA_LAST   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] VF_LAST   = CW'((V_FRONT > 0) ? V_FRONT - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [CW-1:0] line_q, line_d;
  logic          ph_q;
  logic          href_q, href_d;
  logic          vsync_q, vsync_d;
  logic          done_q, done_d;
  logic          uflow_q, uflow_d;
  logic          tp_q, tp_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   word;
  logic          line_last, frame_end, hi_slot;

  always_comb begin
    case (state_q)
      S_VSYNC:  line_last = (line_q == VS_LAST);
      S_VBACK:  line_last = (line_q == VB_LAST);
      S_ACTIVE: line_last = (line_q == VA_LAST);
      default:  line_last = (line_q == VF_LAST);
    endcase
  end

`ifdef DVP_TX_TESTPAT_EN
  logic [2:0]  bar_idx;
  logic [15:0] bar_word;
  logic        frame_start;

  always_comb begin
    bar_idx = 3'((int'(tick_d[CW-1:1]) * 8) / H_ACTIVE);
    case (bar_idx)
      3'd0:    bar_word = 16'hFFFF;
      3'd1:    bar_word = 16'hFFE0;
      3'd2:    bar_word = 16'h07FF;
      3'd3:    bar_word = 16'h07E0;
      3'd4:    bar_word = 16'hF81F;
      3'd5:    bar_word = 16'hF800;
      3'd6:    bar_word = 16'h001F;
      default: bar_word = 16'h0000;
    endcase
  end

  assign frame_start = (state_d == S_VSYNC) && ((state_q == S_IDLE) || frame_end);
  assign tp_d        = frame_start ? test_mode : tp_q;
  assign word        = tp_q ? bar_word : (pix_valid ? pix_data : 16'h0000);
`else
  assign tp_d = 1'b0;
  assign word = pix_valid ? pix_data : 16'h0000;
`endif

  // Next timing position (the tick launched on the coming launch edge) and its outputs.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    line_d    = line_q;
    frame_end = 1'b0;
    if (state_q == S_IDLE) begin
      if (enable) state_d = S_VSYNC;
    end else if (tick_q != TICK_LAST) begin
      tick_d = tick_q + 1'b1;
    end else begin
      tick_d = '0;
      if (!line_last) begin
        line_d = line_q + 1'b1;
      end else begin
        line_d = '0;
        case (state_q)
          S_VSYNC:  state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: if (V_FRONT > 0) state_d = S_VFRONT; else frame_end = 1'b1;
          default:  frame_end = 1'b1;
        endcase
        // enable is only looked at here and in IDLE, so frames are never cut short.
        if (frame_end) state_d = enable ? S_VSYNC : S_IDLE;
      end
    end

    href_d    = (state_d == S_ACTIVE) && (tick_d < HREF_END);
    vsync_d   = (state_d == S_VSYNC);
    hi_slot   = href_d && !tick_d[0];
    pix_ready = ph_q && hi_slot && !tp_q && !rst;
    hold_d    = hi_slot ? word : hold_q;
    data_d    = hi_slot ? word[15:8] : (href_d ? hold_q[7:0] : 8'h00);
    uflow_d   = uflow_q | (pix_ready & ~pix_valid);
    done_d    = ph_q & frame_end;
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      line_q  <= '0;
      ph_q    <= 1'b0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      done_q  <= 1'b0;
      uflow_q <= 1'b0;
      tp_q    <= 1'b0;
      data_q  <= 8'h00;
      hold_q  <= 16'h0000;
    end else begin
      ph_q    <= ~ph_q;
      done_q  <= done_d;
      uflow_q <= uflow_d;
      if (ph_q) begin
        state_q <= state_d;
        tick_q  <= tick_d;
        line_q  <= line_d;
        href_q  <= href_d;
        vsync_q <= vsync_d;
        data_q  <= data_d;
        hold_q  <= hold_d;
        tp_q    <= tp_d;
      end
    end
  end

  assign DVP_PCLK   = ph_q;
  assign DVP_HREF   = href_q;
  assign DVP_VSYNC  = vsync_q;
  assign DVP_DATA   = data_q;
  assign frame_done = done_q;
  assign underflow  = uflow_q;

endmodule
